// File: rtl/dp_pkg.sv
// Shared definitions for the double-pulse checker: state encoding, result codes,
// default timing parameters and the tolerance window helper.
package dp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HIGH1 = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH2 = 3'd3,
        ST_EVAL  = 3'd4
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_HIGH1   = 3'd1;
    localparam logic [2:0] ERR_GAP     = 3'd2;
    localparam logic [2:0] ERR_HIGH2   = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    localparam int DEF_HIGH_NOM = 800;
    localparam int DEF_LOW_NOM  = 520;
    localparam int DEF_TOL      = 8;
    localparam int DEF_TIMEOUT  = 4000;

    // Inclusive window check; done in int so nom - tol can never underflow.
    function automatic logic inTol(input logic [15:0] len, input int nom, input int tol);
        int l;
        l = int'(len);
        return (l >= nom - tol) && (l <= nom + tol);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a registered rise/fall detector.
// An input transition shows up on o_rise/o_fall three clocks later, for one cycle.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;
    logic r_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
            r_fall <= ~r_sync & r_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/double_pulse_checker.sv
// Measures high / gap / high of a gate-drive double pulse and grades each phase
// against its nominal length, with a per-phase timeout.
module double_pulse_checker
    import dp_pkg::*;
#(
    parameter int HIGH_NOM = DEF_HIGH_NOM,
    parameter int LOW_NOM  = DEF_LOW_NOM,
    parameter int TOL      = DEF_TOL,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        pulse_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [2:0]  err_code,
    output logic [15:0] high1_len,
    output logic [15:0] low_len,
    output logic [15:0] high2_len
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    logic        w_rise;
    logic        w_fall;
    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_count;
    logic [15:0] r_high1Len;
    logic [15:0] r_lowLen;
    logic [15:0] r_high2Len;
    logic [2:0]  r_err;
    logic        r_pass;
    logic        w_timeout;
    logic        w_termEdge;
    logic        w_phaseEnd;
    logic [2:0]  w_evalErr;

    sync_edge u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (pulse_in),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_timeout = (r_count >= TIMEOUT_CNT);

    always_comb begin
        w_termEdge = 1'b0;
        case (r_state)
            ST_HIGH1: w_termEdge = w_fall;
            ST_LOW:   w_termEdge = w_rise;
            ST_HIGH2: w_termEdge = w_fall;
            default:  w_termEdge = 1'b0;
        endcase
    end

    assign w_phaseEnd = enable && (r_state inside {ST_HIGH1, ST_LOW, ST_HIGH2})
                        && (w_timeout || w_termEdge);

    // High2 is graded against the live counter since it is latched on the same edge.
    always_comb begin
        w_evalErr = ERR_NONE;
        if (!inTol(r_high1Len, HIGH_NOM, TOL)) begin
            w_evalErr = ERR_HIGH1;
        end else if (!inTol(r_lowLen, LOW_NOM, TOL)) begin
            w_evalErr = ERR_GAP;
        end else if (!inTol(r_count, HIGH_NOM, TOL)) begin
            w_evalErr = ERR_HIGH2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (!enable) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_rise) w_next = ST_HIGH1;
                ST_HIGH1: if (w_phaseEnd) w_next = w_timeout ? ST_EVAL : ST_LOW;
                ST_LOW:   if (w_phaseEnd) w_next = w_timeout ? ST_EVAL : ST_HIGH2;
                ST_HIGH2: if (w_phaseEnd) w_next = ST_EVAL;
                ST_EVAL:  w_next = ST_IDLE;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = enable && ((r_state == ST_IDLE && w_rise)
                          || (r_state inside {ST_HIGH1, ST_LOW, ST_HIGH2}));
        done = enable && (r_state == ST_EVAL);
    end

    // Results are written on the edge into EVAL so they are valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_high1Len <= '0;
            r_lowLen   <= '0;
            r_high2Len <= '0;
            r_err      <= ERR_NONE;
            r_pass     <= 1'b0;
        end else if (!enable) begin
            r_count <= '0;
        end else if (r_state == ST_IDLE) begin
            r_count <= w_rise ? 16'd1 : 16'd0;
        end else if (r_state == ST_EVAL) begin
            r_count <= '0;
        end else if (w_phaseEnd) begin
            r_count <= 16'd1;
            case (r_state)
                ST_HIGH1: r_high1Len <= r_count;
                ST_LOW:   r_lowLen   <= r_count;
                default:  r_high2Len <= r_count;
            endcase
            if (w_timeout) begin
                r_err  <= ERR_TIMEOUT;
                r_pass <= 1'b0;
            end else if (r_state == ST_HIGH2) begin
                r_err  <= w_evalErr;
                r_pass <= (w_evalErr == ERR_NONE);
            end
        end else begin
            r_count <= r_count + 16'd1;
        end
    end

    assign pass      = r_pass;
    assign err_code  = r_err;
    assign high1_len = r_high1Len;
    assign low_len   = r_lowLen;
    assign high2_len = r_high2Len;

endmodule

// File: tb/tb_double_pulse_checker.sv
// Scoreboard bench for double_pulse_checker: each driven double pulse pushes its
// expected result, and a done monitor pops and compares.
module tb_double_pulse_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        pulse_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic [2:0]  err_code;
    logic [15:0] high1_len;
    logic [15:0] low_len;
    logic [15:0] high2_len;

    typedef struct {
        string      name;
        logic       pass;
        logic [2:0] err;
        int         h1;
        int         lo;
        int         h2;
    } exp_t;

    exp_t sb[$];
    int   totalCount = 0;
    int   badCount   = 0;
    int   doneCount  = 0;
    int   lastH2     = 0;

    double_pulse_checker dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .pulse_in  (pulse_in),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_code  (err_code),
        .high1_len (high1_len),
        .low_len   (low_len),
        .high2_len (high2_len)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %0d want %0d", tag, actual, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pops one expectation per done; a done with nothing expected is an error.
    always @(negedge clk) begin
        if (done) begin
            doneCount++;
            if (sb.size() == 0) begin
                checkOutput("spuriousDone", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput({e.name, ".pass"}, 32'(pass), 32'(e.pass));
                checkOutput({e.name, ".err"}, 32'(err_code), 32'(e.err));
                checkOutput({e.name, ".h1"}, 32'(high1_len), e.h1);
                checkOutput({e.name, ".lo"}, 32'(low_len), e.lo);
                checkOutput({e.name, ".h2"}, 32'(high2_len), e.h2);
            end
        end
    end

    task automatic waitDone(input string tag, input int budget);
        int start;
        int n;
        start = doneCount;
        n = 0;
        while (doneCount == start && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput({tag, ".doneSeen"}, 32'(doneCount - start), 32'd1);
    endtask

    task automatic applyStimulus(input string name, input int h1, input int lo, input int h2,
                                 input logic [2:0] expErr);
        exp_t e;
        e.name = name;
        e.pass = (expErr == 3'd0);
        e.err  = expErr;
        e.h1   = h1;
        e.lo   = lo;
        e.h2   = h2;
        sb.push_back(e);
        lastH2 = h2;
        pulse_in = 1'b1;
        cycles(20);
        checkOutput({name, ".busy"}, 32'(busy), 32'd1);
        cycles(h1 - 20);
        pulse_in = 1'b0;
        cycles(lo);
        pulse_in = 1'b1;
        cycles(h2);
        pulse_in = 1'b0;
        waitDone(name, 50);
        cycles(20);
    endtask

    task automatic checkResults(input string tag, input logic p, input logic [2:0] err,
                                input int h1, input int lo, input int h2);
        checkOutput({tag, ".pass"}, 32'(pass), 32'(p));
        checkOutput({tag, ".err"}, 32'(err_code), 32'(err));
        checkOutput({tag, ".h1"}, 32'(high1_len), h1);
        checkOutput({tag, ".lo"}, 32'(low_len), lo);
        checkOutput({tag, ".h2"}, 32'(high2_len), h2);
    endtask

    initial begin
        exp_t e;
        rst      = 1'b1;
        enable   = 1'b1;
        pulse_in = 1'b0;
        cycles(5);
        rst = 1'b0;
        cycles(2);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkResults("reset", 1'b0, 3'd0, 0, 0, 0);

        applyStimulus("nominal",  800, 520, 800, 3'd0);
        applyStimulus("longH1",   900, 520, 800, 3'd1);
        applyStimulus("edgeOk",   808, 512, 792, 3'd0);
        applyStimulus("h1Over",   809, 520, 800, 3'd1);
        applyStimulus("gapShort", 800, 511, 800, 3'd2);
        applyStimulus("h2Short",  800, 520, 791, 3'd3);

        // Single pulse: the gap phase runs into the timeout.
        e.name = "timeout";
        e.pass = 1'b0;
        e.err  = 3'd4;
        e.h1   = 800;
        e.lo   = 4000;
        e.h2   = lastH2;
        sb.push_back(e);
        pulse_in = 1'b1;
        cycles(800);
        pulse_in = 1'b0;
        waitDone("timeout", 4200);
        cycles(20);

        // Reset in the middle of the first high phase.
        pulse_in = 1'b1;
        cycles(300);
        rst      = 1'b1;
        pulse_in = 1'b0;
        cycles(2);
        rst = 1'b0;
        cycles(1);
        checkOutput("midRst.busy", 32'(busy), 32'd0);
        checkOutput("midRst.done", 32'(done), 32'd0);
        checkResults("midRst", 1'b0, 3'd0, 0, 0, 0);
        cycles(600);
        applyStimulus("afterRst", 800, 520, 800, 3'd0);

        // Enable drop during the gap, re-raised while pulse_in is already high.
        pulse_in = 1'b1;
        cycles(800);
        pulse_in = 1'b0;
        cycles(200);
        checkOutput("enDrop.busyBefore", 32'(busy), 32'd1);
        enable = 1'b0;
        cycles(1);
        checkOutput("enDrop.busyLow", 32'(busy), 32'd0);
        pulse_in = 1'b1;
        cycles(20);
        enable = 1'b1;
        cycles(780);
        checkOutput("enDrop.idleHigh", 32'(busy), 32'd0);
        pulse_in = 1'b0;
        cycles(600);
        checkOutput("enDrop.busyAfter", 32'(busy), 32'd0);
        checkResults("enDrop", 1'b1, 3'd0, 800, 520, 800);
        applyStimulus("afterEn", 808, 528, 800, 3'd0);

        cycles(10);
        checkOutput("sbEmpty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
